store_queue: RTL and testbench
==============================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter: DEPTH, 16, number of entries; pointers are 4 bits and usable capacity is 15, so head==tail means empty.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 alloc_valid  input  2  per-slot store allocation request from dispatch, compacted so bit1 is never set without bit0.
REQ-005 alloc_ready  output  1  space exists for two allocations this cycle.
REQ-006 store_head  output  4  index of oldest live entry.
REQ-007 store_tail  output  4  index of next entry to allocate.
REQ-008 wr_valid, wr_idx[3:0], wr_addr[31:0], wr_data[31:0], wr_strb[3:0]  input  address/data fill from the store AGU for entry wr_idx.
REQ-009 commit_valid  input  1  the ROB retires the store at the commit pointer this cycle.
REQ-010 flush  input  1  pipeline flush that discards all uncommitted entries.
REQ-011 dc_req_valid  output  1  a committed store is presented to the dcache.
REQ-012 dc_req_addr[31:0], dc_req_data[31:0], dc_req_strb[3:0]  output  payload of the head entry.
REQ-013 dc_req_ready  input  1  the dcache accepts the request.

Function
REQ-014 Each entry SHALL have a state from {FREE, ALLOC, WRITTEN, COMMITTED}, plus addr, data, and strb fields.
REQ-015 Internal registers SHALL include head, tail, cmt (4 bits each, wrapping modulo 16) and count (5 bits, 0..15).
REQ-016 alloc_ready SHALL equal (count <= 13).
REQ-017 Allocation with alloc_ready=1 and flush=0:
- SHALL move popcount(alloc_valid) entries starting at tail to ALLOC;
- SHALL advance tail by that amount (+0, +1 or +2, with wrap).
REQ-018 When alloc_ready=0, alloc_valid SHALL be ignored and no state SHALL change.
REQ-019 wr_valid SHALL capture addr/data/strb into entry wr_idx and move it ALLOC->WRITTEN one cycle later; a write to a non-ALLOC entry SHALL be ignored.
REQ-020 commit_valid SHALL move entry cmt WRITTEN->COMMITTED and advance cmt by 1.
- commit_valid on a non-WRITTEN entry is an illegal stimulus and SHALL trigger a simulation assertion.
REQ-021 Drain output:
- dc_req_valid SHALL be 1 iff count!=0 and entry head is COMMITTED;
- the payload SHALL be that entry's fields, held stable while dc_req_ready=0.
REQ-022 Drain handshake: dc_req_valid & dc_req_ready SHALL free the head entry and advance head by 1 on the next edge.
REQ-023 Flush: tail SHALL become cmt' (cmt after this cycle's commit) and entries from cmt' to old tail SHALL become FREE.
- A commit in the same cycle is honoured before the discard.
- A dcache drain in the same cycle proceeds normally.
- Allocation SHALL be ignored.
REQ-024 Count update: count SHALL update each cycle by +allocated −drained, or to (cmt'−head'), mod 16, on flush.
- Simultaneous allocation and drain SHALL be netted in one cycle.
REQ-025 Latency: allocate->visible in store_tail is 1 cycle; commit->dc_req_valid is 1 cycle when that entry is at head.
REQ-026 Wrap: index 15 SHALL be followed by index 0 for head, tail and cmt with no bubble.

Reset
REQ-027 On resetn=0, regardless of clk:
- head, tail, cmt and count SHALL be 0;
- all entries SHALL be FREE;
- dc_req_valid=0, dc_req_addr/data/strb=0, alloc_ready=1, store_head=store_tail=0.
REQ-028 Reset asserted mid-drain SHALL drop dc_req_valid immediately; the pending store is lost by design.

Verification
REQ-029 Allocate 2, write idx0 addr=0x1000 data=0xAABBCCDD strb=4'hF, commit 1, hold dc_req_ready=1 -> dc_req_valid=1 with that payload one cycle after commit, then store_head=1, store_tail=2.
REQ-030 Allocate until count=14 -> alloc_ready=0; a further alloc_valid=2'b11 -> store_tail unchanged; one drain -> alloc_ready=1.
REQ-031 Start head=tail=14, allocate 2 per cycle for 2 cycles -> store_tail goes 14, 0, 2; entries 14, 15, 0, 1 are ALLOC.
REQ-032 Three stores allocated, first committed, flush with commit_valid for the second in the same cycle -> store_tail=cmt=2, count=2, third entry FREE.
REQ-033 COMMITTED head with dc_req_ready=0 for 5 cycles -> dc_req_valid stays 1 with stable payload, head unchanged; ready=1 -> head+1.
REQ-034 Assert resetn=0 between clock edges while dc_req_valid=1 -> all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/store_queue_if.sv
// Bundle of the store queue's dispatch, AGU, ROB, flush and dcache-drain signals.
// The queue itself takes the slave view; whoever drives it takes the master view.
interface store_queue_if #(
    parameter int PW = 4
);
    logic [1:0]    alloc_valid;
    logic          alloc_ready;
    logic [PW-1:0] store_head;
    logic [PW-1:0] store_tail;

    logic          wr_valid;
    logic [PW-1:0] wr_idx;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;

    logic          commit_valid;
    logic          flush;

    logic          dc_req_valid;
    logic [31:0]   dc_req_addr;
    logic [31:0]   dc_req_data;
    logic [3:0]    dc_req_strb;
    logic          dc_req_ready;

    modport master (
        output alloc_valid, wr_valid, wr_idx, wr_addr, wr_data, wr_strb,
               commit_valid, flush, dc_req_ready,
        input  alloc_ready, store_head, store_tail,
               dc_req_valid, dc_req_addr, dc_req_data, dc_req_strb
    );

    modport slave (
        input  alloc_valid, wr_valid, wr_idx, wr_addr, wr_data, wr_strb,
               commit_valid, flush, dc_req_ready,
        output alloc_ready, store_head, store_tail,
               dc_req_valid, dc_req_addr, dc_req_data, dc_req_strb
    );
endinterface

// File: rtl/store_queue.sv
// Circular store queue: entries are allocated at tail, filled by the AGU, committed
// in order by the ROB at cmt, and drained to the dcache from head.
module store_queue #(
    parameter int DEPTH = 16
) (
    input logic          clk,
    input logic          resetn,
    store_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef enum logic [1:0] {
        FREE      = 2'd0,
        ALLOC     = 2'd1,
        WRITTEN   = 2'd2,
        COMMITTED = 2'd3
    } entry_state_t;

    entry_state_t state_q [DEPTH];
    entry_state_t state_d [DEPTH];
    logic [31:0]  addr_q  [DEPTH];
    logic [31:0]  data_q  [DEPTH];
    logic [3:0]   strb_q  [DEPTH];

    ptr_t head_q;
    ptr_t tail_q;
    ptr_t cmt_q;
    cnt_t count_q;

    logic       alloc_ready;
    logic       dc_valid;
    logic       drain;
    logic       commit_ok;
    logic       wr_ok;
    logic [1:0] alloc_num;
    ptr_t       head_d;
    ptr_t       tail_d;
    ptr_t       cmt_d;
    ptr_t       flush_span;
    cnt_t       count_d;

    // Pointer and occupancy bookkeeping. Ready demands room for two so dispatch
    // never has to split a pair; a flush rolls tail back to the post-commit pointer.
    always_comb begin
        alloc_ready = (count_q <= cnt_t'(DEPTH - 3));
        dc_valid    = (count_q != '0) && (state_q[head_q] == COMMITTED);
        drain       = dc_valid && bus.dc_req_ready;
        commit_ok   = bus.commit_valid && (state_q[cmt_q] == WRITTEN);
        wr_ok       = bus.wr_valid && (state_q[bus.wr_idx] == ALLOC);

        alloc_num = 2'd0;
        if (alloc_ready && !bus.flush) begin
            alloc_num = {1'b0, bus.alloc_valid[0]} + {1'b0, bus.alloc_valid[1]};
        end

        cmt_d      = cmt_q + ptr_t'(commit_ok);
        head_d     = head_q + ptr_t'(drain);
        flush_span = tail_q - cmt_d;

        if (bus.flush) begin
            tail_d  = cmt_d;
            count_d = {1'b0, ptr_t'(cmt_d - head_d)};
        end else begin
            tail_d  = tail_q + ptr_t'(alloc_num);
            count_d = count_q + cnt_t'(alloc_num) - cnt_t'(drain);
        end
    end

    // Per-entry lifecycle. The events touch disjoint entries (FREE, ALLOC, WRITTEN,
    // COMMITTED respectively), so their order only matters for the flush override.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
        end
        if (alloc_num != 2'd0) begin
            state_d[tail_q] = ALLOC;
        end
        if (alloc_num == 2'd2) begin
            state_d[tail_q + ptr_t'(1)] = ALLOC;
        end
        if (wr_ok) begin
            state_d[bus.wr_idx] = WRITTEN;
        end
        if (commit_ok) begin
            state_d[cmt_q] = COMMITTED;
        end
        if (drain) begin
            state_d[head_q] = FREE;
        end
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ptr_t'(ptr_t'(i) - cmt_d) < flush_span) begin
                    state_d[i] = FREE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            cmt_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FREE;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                strb_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cmt_q   <= cmt_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
            end
            if (wr_ok) begin
                addr_q[bus.wr_idx] <= bus.wr_addr;
                data_q[bus.wr_idx] <= bus.wr_data;
                strb_q[bus.wr_idx] <= bus.wr_strb;
            end
        end
    end

    // Drain payload is read straight from the head entry so it stays put while stalled.
    assign bus.alloc_ready  = alloc_ready;
    assign bus.store_head   = head_q;
    assign bus.store_tail   = tail_q;
    assign bus.dc_req_valid = dc_valid;
    assign bus.dc_req_addr  = addr_q[head_q];
    assign bus.dc_req_data  = data_q[head_q];
    assign bus.dc_req_strb  = strb_q[head_q];

    commit_legal: assert property (
        @(posedge clk) disable iff (!resetn)
        bus.commit_valid |-> (state_q[cmt_q] == WRITTEN)
    );
endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios plus random traffic, all checked every
// cycle against an in-order list model of the live stores.
module tb_store_queue;
    localparam int ST_FREE      = 0;
    localparam int ST_ALLOC     = 1;
    localparam int ST_WRITTEN   = 2;
    localparam int ST_COMMITTED = 3;

    typedef struct {
        int          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Live stores, oldest first; queue position p lives at index (m_head + p) % 16.
    entry_t mq[$];
    int     m_head = 0;

    store_queue_if bus ();

    store_queue dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int num_committed();
        int n;
        n = 0;
        while (n < mq.size() && mq[n].st == ST_COMMITTED) n++;
        return n;
    endfunction

    function automatic int model_state(input int idx);
        int pos;
        pos = (idx - m_head + 16) % 16;
        if (pos < mq.size()) return mq[pos].st;
        return ST_FREE;
    endfunction

    function automatic bit model_valid();
        return (mq.size() != 0) && (mq[0].st == ST_COMMITTED);
    endfunction

    task automatic zero_inputs();
        bus.alloc_valid  = 2'b00;
        bus.wr_valid     = 1'b0;
        bus.wr_idx       = 4'd0;
        bus.wr_addr      = 32'h0;
        bus.wr_data      = 32'h0;
        bus.wr_strb      = 4'h0;
        bus.commit_valid = 1'b0;
        bus.flush        = 1'b0;
        bus.dc_req_ready = 1'b0;
    endtask

    task automatic checkState();
        checkOutput("alloc_ready", 64'(bus.alloc_ready), 64'(mq.size() <= 13));
        checkOutput("store_head", 64'(bus.store_head), 64'(m_head));
        checkOutput("store_tail", 64'(bus.store_tail), 64'((m_head + mq.size()) % 16));
        checkOutput("dc_req_valid", 64'(bus.dc_req_valid), 64'(model_valid()));
        if (model_valid()) begin
            checkOutput("dc_req_addr", 64'(bus.dc_req_addr), 64'(mq[0].addr));
            checkOutput("dc_req_data", 64'(bus.dc_req_data), 64'(mq[0].data));
            checkOutput("dc_req_strb", 64'(bus.dc_req_strb), 64'(mq[0].strb));
        end
    endtask

    task automatic modelStep(input logic [1:0] av, input logic wv, input logic [3:0] widx,
                             input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                             input logic cv, input logic fl, input logic rdy);
        int cnt;
        int ncm;
        int wpos;
        int nalloc;
        bit do_commit;
        bit do_drain;
        cnt       = mq.size();
        ncm       = num_committed();
        do_commit = cv && (ncm < cnt) && (mq[ncm].st == ST_WRITTEN);
        do_drain  = model_valid() && rdy;
        wpos      = (int'(widx) - m_head + 16) % 16;
        nalloc    = 0;
        if (cnt <= 13 && !fl) nalloc = int'(av[0]) + int'(av[1]);
        if (wv && wpos < cnt && mq[wpos].st == ST_ALLOC) begin
            mq[wpos].st   = ST_WRITTEN;
            mq[wpos].addr = wa;
            mq[wpos].data = wd;
            mq[wpos].strb = ws;
        end
        if (do_commit) mq[ncm].st = ST_COMMITTED;
        if (fl) begin
            while (mq.size() > ncm + int'(do_commit)) void'(mq.pop_back());
        end else begin
            for (int k = 0; k < nalloc; k++) mq.push_back('{ST_ALLOC, 32'h0, 32'h0, 4'h0});
        end
        if (do_drain) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % 16;
        end
    endtask

    // One clock: drive, check registered outputs at the falling edge, then advance the model.
    task automatic applyStimulus(input logic [1:0] av, input logic wv, input logic [3:0] widx,
                                 input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                                 input logic cv, input logic fl, input logic rdy);
        bus.alloc_valid  = av;
        bus.wr_valid     = wv;
        bus.wr_idx       = widx;
        bus.wr_addr      = wa;
        bus.wr_data      = wd;
        bus.wr_strb      = ws;
        bus.commit_valid = cv;
        bus.flush        = fl;
        bus.dc_req_ready = rdy;
        @(negedge clk);
        checkState();
        modelStep(av, wv, widx, wa, wd, ws, cv, fl, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_valid"}, 64'(bus.dc_req_valid), 64'd0);
        checkOutput({tag, "_addr"}, 64'(bus.dc_req_addr), 64'd0);
        checkOutput({tag, "_data"}, 64'(bus.dc_req_data), 64'd0);
        checkOutput({tag, "_strb"}, 64'(bus.dc_req_strb), 64'd0);
        checkOutput({tag, "_ready"}, 64'(bus.alloc_ready), 64'd1);
        checkOutput({tag, "_head"}, 64'(bus.store_head), 64'd0);
        checkOutput({tag, "_tail"}, 64'(bus.store_tail), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        zero_inputs();
        mq.delete();
        m_head = 0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          cnt;
        int          ncm;
        int          sel;
        logic [1:0]  av;
        logic        wv;
        logic        cv;
        logic        fl;
        logic        rdy;
        logic [3:0]  widx;
        logic [31:0] held_addr;

        zero_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Basic allocate / fill / commit / drain with dcache always ready.
        applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b1, 4'd0, 32'h1000, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("basic_valid", 64'(bus.dc_req_valid), 64'd1);
        checkOutput("basic_addr", 64'(bus.dc_req_addr), 64'h1000);
        checkOutput("basic_data", 64'(bus.dc_req_data), 64'hAABBCCDD);
        checkOutput("basic_strb", 64'(bus.dc_req_strb), 64'hF);
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_head", 64'(bus.store_head), 64'd1);
        checkOutput("basic_tail", 64'(bus.store_tail), 64'd2);

        // Fill to 14 entries, confirm backpressure, then free one slot.
        do_reset();
        for (int i = 0; i < 7; i++) applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_ready", 64'(bus.alloc_ready), 64'd0);
        applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_tail", 64'(bus.store_tail), 64'd14);
        applyStimulus(2'b00, 1'b1, 4'd0, 32'h40, 32'h1234, 4'h3, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("refill_ready", 64'(bus.alloc_ready), 64'd1);

        // Walk the pointers to 14, then allocate across the wrap.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(2'b01, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            applyStimulus(2'b00, 1'b1, 4'(i), $urandom, $urandom, 4'hF, 1'b0, 1'b0, 1'b0);
            applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
            applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("wrap_tail14", 64'(bus.store_tail), 64'd14);
        applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_tail0", 64'(bus.store_tail), 64'd0);
        applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_tail2", 64'(bus.store_tail), 64'd2);
        foreach (dut.state_q[i]) begin
            checkOutput($sformatf("wrap_state%0d", i), 64'(dut.state_q[i]), 64'(model_state(i)));
        end
        checkOutput("wrap_alloc15", 64'(dut.state_q[15]), 64'(ST_ALLOC));
        checkOutput("wrap_alloc1", 64'(dut.state_q[1]), 64'(ST_ALLOC));

        // Flush with a same-cycle commit of the second of three stores.
        do_reset();
        applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 4'd0, 32'h2000, 32'h11111111, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 4'd1, 32'h2004, 32'h22222222, 4'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 4'd2, 32'h2008, 32'h33333333, 4'h4, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_tail", 64'(bus.store_tail), 64'd2);
        checkOutput("flush_cmt", 64'(dut.cmt_q), 64'd2);
        checkOutput("flush_count", 64'(dut.count_q), 64'd2);
        checkOutput("flush_free2", 64'(dut.state_q[2]), 64'(ST_FREE));

        // Stalled drain holds its payload, then completes.
        held_addr = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            checkOutput("stall_valid", 64'(bus.dc_req_valid), 64'd1);
            checkOutput("stall_addr", 64'(bus.dc_req_addr), 64'(held_addr));
            checkOutput("stall_head", 64'(bus.store_head), 64'd0);
        end
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("stall_release_head", 64'(bus.store_head), 64'd1);

        // Reset dropped between edges while a drain is pending.
        do_reset();
        applyStimulus(2'b01, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 4'd0, 32'hDEAD0000, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_pre_valid", 64'(bus.dc_req_valid), 64'd1);
        #2;
        zero_inputs();
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        mq.delete();
        m_head = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic; commits are only issued when the model says they are legal.
        for (int n = 0; n < 1500; n++) begin
            cnt = mq.size();
            ncm = num_committed();
            sel = int'($urandom_range(0, 2));
            av  = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b11);
            wv  = ($urandom_range(0, 3) != 0);
            if (cnt > 0 && $urandom_range(0, 3) != 0) begin
                widx = 4'((m_head + int'($urandom_range(0, cnt - 1))) % 16);
            end else begin
                widx = 4'($urandom_range(0, 15));
            end
            cv = 1'b0;
            if (ncm < cnt) begin
                if (mq[ncm].st == ST_WRITTEN && $urandom_range(0, 1) == 1) cv = 1'b1;
            end
            fl  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(av, wv, widx, $urandom, $urandom, 4'($urandom_range(0, 15)), cv, fl, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
